// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared op encodings, bundle widths and divider states for the EXE stage
package exe_stage_pkg;
  localparam int DIV_CYCLES = 32;
  localparam int RF_W = 6;
  localparam int MEM_W = 8;
  localparam int CSR_W = 79;
  localparam int EXC_W = 6;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_NOR = 5;
  localparam int ALU_OR = 6;
  localparam int ALU_XOR = 7;
  localparam int ALU_SLL = 8;
  localparam int ALU_SRL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_LUI = 11;
  localparam int MUL_W = 0;
  localparam int MULH_W = 1;
  localparam int MULH_WU = 2;
  localparam int DIV_W = 0;
  localparam int MOD_W = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;
  localparam int MEM_ST_W = 0;
  localparam int MEM_ST_H = 1;
  localparam int MEM_ST_B = 2;
  localparam int MEM_LD_SE = 3;
  localparam int MEM_LD_W = 4;
  localparam int MEM_LD_H = 5;
  localparam int MEM_LD_B = 6;
  localparam int MEM_WE = 7;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/alu.sv
// alu: single-cycle integer ALU driven by a one-hot 12-bit op
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic        sub_like;
  logic [31:0] b_in;
  logic [32:0] adder;
  logic        slt;
  logic        sltu;
  logic [31:0] sra_res;
  assign sub_like = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
  assign b_in = sub_like ? ~alu_src2 : alu_src2;
  assign adder = {1'b0, alu_src1} + {1'b0, b_in} + {32'b0, sub_like};
  assign slt = (alu_src1[31] & ~alu_src2[31]) | (~(alu_src1[31] ^ alu_src2[31]) & adder[31]);
  assign sltu = ~adder[32];
  assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];
  assign alu_result = ({32{alu_op[ALU_ADD] | alu_op[ALU_SUB]}} & adder[31:0])
                    | ({32{alu_op[ALU_SLT]}} & {31'b0, slt})
                    | ({32{alu_op[ALU_SLTU]}} & {31'b0, sltu})
                    | ({32{alu_op[ALU_AND]}} & (alu_src1 & alu_src2))
                    | ({32{alu_op[ALU_NOR]}} & ~(alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_OR]}} & (alu_src1 | alu_src2))
                    | ({32{alu_op[ALU_XOR]}} & (alu_src1 ^ alu_src2))
                    | ({32{alu_op[ALU_SLL]}} & (alu_src1 << alu_src2[4:0]))
                    | ({32{alu_op[ALU_SRL]}} & (alu_src1 >> alu_src2[4:0]))
                    | ({32{alu_op[ALU_SRA]}} & sra_res)
                    | ({32{alu_op[ALU_LUI]}} & alu_src2);
endmodule

// File: rtl/exe_stage_div_iter.sv
// div_iter: restoring radix-2 divider, one quotient bit per cycle, sign fixed up on output
module div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        cancel,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] d;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] r_sh;
  logic        fits;
  assign abs_a = (sign & a[31]) ? -a : a;
  assign abs_b = (sign & b[31]) ? -b : b;
  assign r_sh = {r, q[31]};
  assign fits = r_sh >= {1'b0, d};
  assign busy = state == DIV_BUSY;
  assign done = state == DIV_DONE;
  assign quo = neg_q ? -q : q;
  assign rem = neg_r ? -r : r;
  // state machine plus shift/subtract datapath; a zero divisor keeps the quotient all ones
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt <= 5'd0;
      q <= 32'd0;
      r <= 32'd0;
      d <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (cancel) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state <= DIV_BUSY;
          cnt <= 5'd0;
          q <= abs_a;
          r <= 32'd0;
          d <= abs_b;
          neg_q <= sign & (a[31] ^ b[31]) & (|b);
          neg_r <= sign & a[31];
        end
        DIV_BUSY: begin
          q <= {q[30:0], fits};
          r <= fits ? r_sh[31:0] - d : r_sh[31:0];
          cnt <= cnt + 5'd1;
          state <= (cnt == 5'(DIV_CYCLES - 1)) ? DIV_DONE : DIV_BUSY;
        end
        DIV_DONE: state <= ack ? DIV_IDLE : DIV_DONE;
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage; ALU, multiply and iterative divide feeding the memory stage
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_to_exe_valid,
  output logic              exe_allowin,
  input  logic [31:0]       id_pc,
  input  logic [11:0]       id_alu_op,
  input  logic [2:0]        id_mul_op,
  input  logic [3:0]        id_div_op,
  input  logic [31:0]       id_src1,
  input  logic [31:0]       id_src2,
  input  logic [31:0]       id_rkd_value,
  input  logic [RF_W-1:0]   id_rf_all,
  input  logic              id_res_from_mem,
  input  logic [MEM_W-1:0]  id_mem_all,
  input  logic [CSR_W-1:0]  id_csr_rf,
  input  logic [EXC_W-1:0]  id_exc_rf,
  input  logic              mem_allowin,
  input  logic              cancel_exc_ertn,
  output logic              exe_to_mem_valid,
  output logic [31:0]       exe_pc,
  output logic [31:0]       exe_result,
  output logic              exe_res_from_mem,
  output logic [MEM_W-1:0]  exe_mem_all,
  output logic [31:0]       exe_rkd_value,
  output logic [RF_W-1:0]   exe_rf_all,
  output logic [CSR_W-1:0]  exe_csr_rf,
  output logic [EXC_W-1:0]  exe_exc_rf,
  output logic [38:0]       exe_fwd
);
  logic        exe_valid;
  logic        exe_ready_go;
  logic [11:0] alu_op;
  logic [2:0]  mul_op;
  logic [3:0]  div_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [RF_W-1:0] rf_all;
  logic [31:0] alu_result;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic        msign;
  logic        is_mul;
  logic        is_div;
  logic        is_mod;
  logic        div_sign;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic        div_busy_fwd;
  logic [31:0] quo;
  logic [31:0] rem;
  assign is_mul = |mul_op;
  assign is_div = |div_op;
  assign is_mod = div_op[MOD_W] | div_op[MOD_WU];
  assign div_sign = div_op[DIV_W] | div_op[MOD_W];
  assign exe_ready_go = ~is_div | div_done;
  assign exe_allowin = ~exe_valid | (exe_ready_go & mem_allowin) | cancel_exc_ertn;
  assign exe_to_mem_valid = exe_valid & exe_ready_go;
  assign div_start = exe_valid & is_div & ~div_busy & ~div_done & ~cancel_exc_ertn;
  assign msign = ~mul_op[MULH_WU];
  assign ma = {{32{msign & src1[31]}}, src1};
  assign mb = {{32{msign & src2[31]}}, src2};
  assign prod = ma * mb;
  assign exe_result = is_div ? (is_mod ? rem : quo)
                    : is_mul ? (mul_op[MUL_W] ? prod[31:0] : prod[63:32])
                    : alu_result;
  assign exe_rf_all = {rf_all[5] & exe_valid, rf_all[4:0]};
  assign div_busy_fwd = is_div & ~div_done;
  assign exe_fwd = {exe_valid & rf_all[5], rf_all[4:0], exe_res_from_mem | div_busy_fwd, exe_result};
  // stage valid bit; a WB flush empties the stage
  always_ff @(posedge clk) begin
    if (!resetn) exe_valid <= 1'b0;
    else exe_valid <= cancel_exc_ertn ? 1'b0 : (exe_allowin ? id_to_exe_valid : exe_valid);
  end
  // latch the ID bundle whenever a new instruction is accepted
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_all <= '0;
      exe_exc_rf <= '0;
    end else if (id_to_exe_valid & exe_allowin) begin
      exe_pc <= id_pc;
      alu_op <= id_alu_op;
      mul_op <= id_mul_op;
      div_op <= id_div_op;
      src1 <= id_src1;
      src2 <= id_src2;
      exe_rkd_value <= id_rkd_value;
      rf_all <= id_rf_all;
      exe_res_from_mem <= id_res_from_mem;
      exe_mem_all <= id_mem_all;
      exe_csr_rf <= id_csr_rf;
      exe_exc_rf <= id_exc_rf;
    end
  end
  alu u_alu (
    .alu_op(alu_op),
    .alu_src1(src1),
    .alu_src2(src2),
    .alu_result(alu_result)
  );
  div_iter u_div (
    .clk(clk),
    .resetn(resetn),
    .start(div_start),
    .cancel(cancel_exc_ertn),
    .sign(div_sign),
    .a(src1),
    .b(src2),
    .ack(exe_to_mem_valid & mem_allowin),
    .busy(div_busy),
    .done(div_done),
    .quo(quo),
    .rem(rem)
  );
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vector table plus hand sequences for flush, stall and pass-through
module tb_exe_stage;
  import exe_stage_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  logic        id_to_exe_valid = 1'b0;
  logic        exe_allowin;
  logic [31:0] id_pc = 32'h1c00_0000;
  logic [11:0] id_alu_op = '0;
  logic [2:0]  id_mul_op = '0;
  logic [3:0]  id_div_op = '0;
  logic [31:0] id_src1 = '0;
  logic [31:0] id_src2 = '0;
  logic [31:0] id_rkd_value = '0;
  logic [5:0]  id_rf_all = 6'h21;
  logic        id_res_from_mem = 1'b0;
  logic [7:0]  id_mem_all = '0;
  logic [78:0] id_csr_rf = '0;
  logic [5:0]  id_exc_rf = '0;
  logic        mem_allowin = 1'b1;
  logic        cancel_exc_ertn = 1'b0;
  logic        exe_to_mem_valid;
  logic [31:0] exe_pc;
  logic [31:0] exe_result;
  logic        exe_res_from_mem;
  logic [7:0]  exe_mem_all;
  logic [31:0] exe_rkd_value;
  logic [5:0]  exe_rf_all;
  logic [78:0] exe_csr_rf;
  logic [5:0]  exe_exc_rf;
  logic [38:0] exe_fwd;
  exe_stage dut (
    .clk(clk), .resetn(resetn), .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
    .id_pc(id_pc), .id_alu_op(id_alu_op), .id_mul_op(id_mul_op), .id_div_op(id_div_op),
    .id_src1(id_src1), .id_src2(id_src2), .id_rkd_value(id_rkd_value), .id_rf_all(id_rf_all),
    .id_res_from_mem(id_res_from_mem), .id_mem_all(id_mem_all), .id_csr_rf(id_csr_rf),
    .id_exc_rf(id_exc_rf), .mem_allowin(mem_allowin), .cancel_exc_ertn(cancel_exc_ertn),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_pc(exe_pc), .exe_result(exe_result),
    .exe_res_from_mem(exe_res_from_mem), .exe_mem_all(exe_mem_all), .exe_rkd_value(exe_rkd_value),
    .exe_rf_all(exe_rf_all), .exe_csr_rf(exe_csr_rf), .exe_exc_rf(exe_exc_rf), .exe_fwd(exe_fwd)
  );
  typedef struct {
    logic [11:0] alu;
    logic [2:0]  mul;
    logic [3:0]  div;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic [11:0] aop(input int i);
    return 12'(1) << i;
  endfunction
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [11:0] a, input logic [2:0] m, input logic [3:0] d,
                       input logic [31:0] s1, input logic [31:0] s2);
    @(negedge clk);
    id_alu_op = a;
    id_mul_op = m;
    id_div_op = d;
    id_src1 = s1;
    id_src2 = s2;
    id_to_exe_valid = 1'b1;
    @(posedge clk);
    #1;
    id_to_exe_valid = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (!exe_to_mem_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  vec_t vt[20];
  int lat;
  initial begin
    vt[0]  = '{aop(ALU_ADD), 3'b000, 4'b0000, 32'd3, 32'd5, 32'd8, 0};
    vt[1]  = '{aop(ALU_SUB), 3'b000, 4'b0000, 32'd10, 32'd3, 32'd7, 0};
    vt[2]  = '{aop(ALU_SLT), 3'b000, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 0};
    vt[3]  = '{aop(ALU_SLTU), 3'b000, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 0};
    vt[4]  = '{aop(ALU_NOR), 3'b000, 4'b0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 0};
    vt[5]  = '{aop(ALU_SRA), 3'b000, 4'b0000, 32'h8000_0000, 32'd4, 32'hF800_0000, 0};
    vt[6]  = '{aop(ALU_SLL), 3'b000, 4'b0000, 32'd1, 32'd31, 32'h8000_0000, 0};
    vt[7]  = '{aop(ALU_LUI), 3'b000, 4'b0000, 32'd0, 32'h1234_5000, 32'h1234_5000, 0};
    vt[8]  = '{12'd0, 3'b010, 4'b0000, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 0};
    vt[9]  = '{12'd0, 3'b100, 4'b0000, 32'h8000_0000, 32'd2, 32'd1, 0};
    vt[10] = '{12'd0, 3'b001, 4'b0000, 32'h8000_0000, 32'd2, 32'd0, 0};
    vt[11] = '{12'd0, 3'b000, 4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    vt[12] = '{12'd0, 3'b000, 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    vt[13] = '{12'd0, 3'b000, 4'b0100, 32'd5, 32'd0, 32'hFFFF_FFFF, 33};
    vt[14] = '{12'd0, 3'b000, 4'b1000, 32'd5, 32'd0, 32'd5, 33};
    vt[15] = '{12'd0, 3'b000, 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vt[16] = '{12'd0, 3'b000, 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
    vt[17] = '{12'd0, 3'b000, 4'b0001, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vt[18] = '{12'd0, 3'b000, 4'b0010, 32'd7, 32'hFFFF_FFFE, 32'd1, 33};
    vt[19] = '{12'd0, 3'b000, 4'b0100, 32'd100, 32'd7, 32'd14, 33};
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset exe_to_mem_valid", 80'(exe_to_mem_valid), 80'd0);
    check("reset exe_allowin", 80'(exe_allowin), 80'd1);
    check("reset exe_rf_all", 80'(exe_rf_all), 80'd0);
    check("reset exe_exc_rf", 80'(exe_exc_rf), 80'd0);
    check("reset fwd we", 80'(exe_fwd[38]), 80'd0);
    for (int i = 0; i < 20; i++) begin
      issue(vt[i].alu, vt[i].mul, vt[i].div, vt[i].s1, vt[i].s2);
      check($sformatf("vec%0d fwd stall bit", i), 80'(exe_fwd[32]), 80'(vt[i].lat != 0));
      wait_out(lat);
      check($sformatf("vec%0d latency", i), 80'(lat), 80'(vt[i].lat));
      check($sformatf("vec%0d result", i), 80'(exe_result), 80'(vt[i].exp));
    end
    id_res_from_mem = 1'b1;
    id_mem_all = 8'(1) << MEM_LD_W;
    id_rf_all = 6'h2A;
    id_pc = 32'h1c00_0040;
    id_rkd_value = 32'hDEAD_BEEF;
    id_csr_rf = {15'h5A5A, 64'h0123_4567_89AB_CDEF};
    id_exc_rf = 6'h15;
    issue(aop(ALU_ADD), 3'b000, 4'b0000, 32'h100, 32'h4);
    check("load fwd stall bit", 80'(exe_fwd[32]), 80'd1);
    check("load fwd we/waddr", 80'(exe_fwd[38:33]), 80'h2A);
    check("load result", 80'(exe_result), 80'h104);
    check("load rf_all", 80'(exe_rf_all), 80'h2A);
    check("load mem_all", 80'(exe_mem_all), 80'(8'(1) << MEM_LD_W));
    check("load pc", 80'(exe_pc), 80'h1c00_0040);
    check("load rkd", 80'(exe_rkd_value), 80'hDEAD_BEEF);
    check("load csr", 80'(exe_csr_rf), 80'({15'h5A5A, 64'h0123_4567_89AB_CDEF}));
    check("load exc", 80'(exe_exc_rf), 80'h15);
    check("load res_from_mem", 80'(exe_res_from_mem), 80'd1);
    @(posedge clk);
    #1;
    check("drained rf we gated", 80'(exe_rf_all), 80'h0A);
    check("drained valid", 80'(exe_to_mem_valid), 80'd0);
    id_res_from_mem = 1'b0;
    id_mem_all = '0;
    id_rf_all = 6'h21;
    issue(12'd0, 3'b000, 4'b0001, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel_exc_ertn = 1'b1;
    @(posedge clk);
    #1;
    cancel_exc_ertn = 1'b0;
    check("cancel valid", 80'(exe_to_mem_valid), 80'd0);
    check("cancel fwd we", 80'(exe_fwd[38]), 80'd0);
    check("cancel allowin", 80'(exe_allowin), 80'd1);
    check("cancel fsm busy", 80'(dut.u_div.busy), 80'd0);
    check("cancel fsm done", 80'(dut.u_div.done), 80'd0);
    issue(aop(ALU_ADD), 3'b000, 4'b0000, 32'd1, 32'd2);
    wait_out(lat);
    check("post-cancel add latency", 80'(lat), 80'd0);
    check("post-cancel add result", 80'(exe_result), 80'd3);
    @(posedge clk);
    #1;
    mem_allowin = 1'b0;
    issue(12'd0, 3'b000, 4'b0100, 32'd100, 32'd7);
    wait_out(lat);
    check("stall div latency", 80'(lat), 80'd33);
    check("stall div result", 80'(exe_result), 80'd14);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d result", k), 80'(exe_result), 80'd14);
      check($sformatf("stall%0d allowin", k), 80'(exe_allowin), 80'd0);
      check($sformatf("stall%0d valid", k), 80'(exe_to_mem_valid), 80'd1);
    end
    @(negedge clk);
    mem_allowin = 1'b1;
    #1;
    check("release allowin", 80'(exe_allowin), 80'd1);
    @(posedge clk);
    #1;
    check("after handshake valid", 80'(exe_to_mem_valid), 80'd0);
    check("after handshake fsm busy", 80'(dut.u_div.busy), 80'd0);
    check("after handshake fsm done", 80'(dut.u_div.done), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
